// File: rtl/spi_bus_if.sv
// spi_bus_if: requester handshake and SPI pins for spi_bus_scheduler.
//   req          3 level requests, one per slave (requester i -> slave i)
//   wr_data      per-requester tx words, slot i belongs to requester i
//   ack          one-cycle done pulse to the granted requester
//   rd_data      last received word, held until the next ack
//   busy         transfer in flight (grant through end of gap)
//   slave_select chip-select demux index, changes only while spi_cs is high
//   spi_*        shared mode-0 SPI lines, spi_cs active low
interface spi_bus_if #(
  parameter int DATA_W = 16
);
  logic [2:0]             req;
  logic [2:0][DATA_W-1:0] wr_data;
  logic [2:0]             ack;
  logic [DATA_W-1:0]      rd_data;
  logic                   busy;
  logic [1:0]             slave_select;
  logic                   spi_cs;
  logic                   spi_sclk;
  logic                   spi_mosi;
  logic                   spi_miso;

  modport master (
    input  req, wr_data, spi_miso,
    output ack, rd_data, busy, slave_select, spi_cs, spi_sclk, spi_mosi
  );

  modport slave (
    output req, wr_data, spi_miso,
    input  ack, rd_data, busy, slave_select, spi_cs, spi_sclk, spi_mosi
  );
endinterface

// File: rtl/spi_bus_scheduler.sv
// spi_bus_scheduler: round-robin SPI master shared by three requesters.
// Grants one requester at a time and runs a mode-0, MSB-first transfer of
// DATA_W bits. SCLK half-period is HALF_DIV clk cycles.
// Ports:
//   clk_i   system clock, rising edge
//   rst_ni  asynchronous active-low reset
//   bus     spi_bus_if.master (requests/acks, rx word, SPI pins, CS demux)
// All outputs are registered so SPI_CS/SCLK/MOSI never glitch.
module spi_bus_scheduler #(
  parameter int DATA_W   = 16,
  parameter int HALF_DIV = 4
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  spi_bus_if.master bus
);
  localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int HW = $clog2(2 * DATA_W);
  localparam logic [CW-1:0] CNT_LAST  = CW'(HALF_DIV - 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(2 * DATA_W - 1);
  localparam logic [HW-1:0] FALL_LAST = HW'(2 * DATA_W - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_LEAD, S_SHIFT, S_TRAIL, S_GAP
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        sel_q, sel_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [HW-1:0]     half_q, half_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic [2:0]        ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              cs_q, cs_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;

  // Round-robin pick: first set request at or after the pointer (mod 3).
  // Scanning from the farthest offset down lets the nearest one win.
  logic [1:0] gnt;
  logic       gnt_vld;
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_vld = 1'b0;
    for (int k = 2; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= 3) idx = idx - 3;
      if (bus.req[idx]) begin
        gnt     = 2'(idx);
        gnt_vld = 1'b1;
      end
    end
  end

  wire last_cyc = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q + 1'b1;
    half_d  = half_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rd_d    = rd_q;
    ack_d   = '0;
    busy_d  = busy_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (gnt_vld) begin
          sel_d   = gnt;
          ptr_d   = (gnt == 2'd2) ? 2'd0 : gnt + 2'd1;
          tx_d    = bus.wr_data[gnt];
          busy_d  = 1'b1;
          state_d = S_SELECT;
        end
      end
      // CS stays high one cycle so the demux index is stable before CS falls.
      S_SELECT: begin
        cnt_d   = '0;
        mosi_d  = tx_q[DATA_W-1];
        cs_d    = 1'b0;
        state_d = S_LEAD;
      end
      // The lead-in is the setup half for the first rising edge.
      S_LEAD: if (last_cyc) begin
        cnt_d   = '0;
        half_d  = '0;
        sclk_d  = 1'b1;
        rx_d    = {rx_q[DATA_W-2:0], bus.spi_miso};
        state_d = S_SHIFT;
      end
      // Even halves are high, odd halves low; the last half is low and
      // runs straight into the trail.
      S_SHIFT: if (last_cyc) begin
        cnt_d  = '0;
        half_d = half_q + 1'b1;
        if (half_q == HALF_LAST) begin
          state_d = S_TRAIL;
        end else if (!half_q[0]) begin
          sclk_d = 1'b0;
          if (half_q != FALL_LAST) begin
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
            mosi_d = tx_q[DATA_W-2];
          end
        end else begin
          sclk_d = 1'b1;
          rx_d   = {rx_q[DATA_W-2:0], bus.spi_miso};
        end
      end
      S_TRAIL: if (last_cyc) begin
        cnt_d        = '0;
        cs_d         = 1'b1;
        ack_d[sel_q] = 1'b1;
        rd_d         = rx_q;
        mosi_d       = 1'b0;
        state_d      = S_GAP;
      end
      S_GAP: if (last_cyc) begin
        cnt_d   = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      half_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rd_q    <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rd_q    <= rd_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
    end
  end

  assign bus.ack          = ack_q;
  assign bus.rd_data      = rd_q;
  assign bus.busy         = busy_q;
  assign bus.slave_select = sel_q;
  assign bus.spi_cs       = cs_q;
  assign bus.spi_sclk     = sclk_q;
  assign bus.spi_mosi     = mosi_q;
endmodule

// File: tb/tb_spi_bus_scheduler.sv
module tb_spi_bus_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_bus_if #(.DATA_W(16)) ba ();
  spi_bus_if #(.DATA_W(8))  bb ();

  spi_bus_scheduler #(.DATA_W(16), .HALF_DIV(4)) ua (.clk_i(clk), .rst_ni(rst_n), .bus(ba));
  spi_bus_scheduler #(.DATA_W(8),  .HALF_DIV(1)) ub (.clk_i(clk), .rst_ni(rst_n), .bus(bb));

  int checks = 0;
  int errors = 0;
  int mptr;

  // MISO source for bus A: 0 = loopback of MOSI, 1 = pattern word MSB-first
  int          miso_mode = 0;
  logic [15:0] pat = '0;
  int          m_rises;
  assign ba.spi_miso = (miso_mode == 0) ? ba.spi_mosi :
                       ((m_rises < 16) ? pat[15 - m_rises] : 1'b0);
  assign bb.spi_miso = 1'b1;

  // Bus A observer: one record per completed CS-low window, plus ack events.
  int          xq_len[$], xq_rise[$], xq_sel[$], xq_selbad[$], gaps[$];
  logic [15:0] xq_mosi[$];
  logic [2:0]  aq[$];
  logic [15:0] rq[$];
  int          ack_long, sclk_idle_bad;
  int          cur_len, hi_cnt, sel0, selbad;
  logic [15:0] mw;
  logic        cs_prev, sclk_prev, ack_prev;

  always @(negedge clk) begin
    if (!rst_n) begin
      cs_prev = 1'b1; sclk_prev = 1'b0; ack_prev = 1'b0;
      cur_len = 0; m_rises = 0; hi_cnt = 0;
    end else begin
      if (!ba.spi_cs) begin
        if (cs_prev) begin
          gaps.push_back(hi_cnt);
          hi_cnt = 0; cur_len = 0; m_rises = 0; mw = '0;
          sel0 = int'(ba.slave_select); selbad = 0;
        end
        cur_len++;
        if (int'(ba.slave_select) != sel0) selbad = 1;
        if (ba.spi_sclk && !sclk_prev) begin
          m_rises++;
          mw = {mw[14:0], ba.spi_mosi};
        end
      end else begin
        if (!cs_prev) begin
          xq_len.push_back(cur_len); xq_rise.push_back(m_rises);
          xq_sel.push_back(sel0); xq_selbad.push_back(selbad);
          xq_mosi.push_back(mw);
        end
        hi_cnt++;
        if (ba.spi_sclk) sclk_idle_bad++;
      end
      if (ba.ack != 3'b0) begin
        aq.push_back(ba.ack); rq.push_back(ba.rd_data);
        if (ack_prev) ack_long++;
      end
      cs_prev = ba.spi_cs; sclk_prev = ba.spi_sclk; ack_prev = (ba.ack != 3'b0);
    end
  end

  // Reference arbiter: first requester at or after the pointer, mod 3.
  function automatic int rr_pick(int ptr, logic [2:0] r);
    for (int k = 0; k < 3; k++)
      if (r[(ptr + k) % 3]) return (ptr + k) % 3;
    return -1;
  endfunction

  task automatic clear_mon();
    @(posedge clk);
    xq_len.delete(); xq_rise.delete(); xq_sel.delete(); xq_selbad.delete();
    xq_mosi.delete(); aq.delete(); rq.delete(); gaps.delete();
    ack_long = 0; sclk_idle_bad = 0;
  endtask

  task automatic do_reset();
    ba.req = '0; bb.req = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mptr = 0;
    clear_mon();
  endtask

  task automatic wait_ack(output logic [2:0] a, output bit ok);
    ok = 0; a = '0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (ba.ack != 3'b0) begin a = ba.ack; ok = 1; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL ack_timeout got none exp ack within 2000 cycles");
    end
  endtask

  task automatic wait_cs_low_a(output bit ok);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (!ba.spi_cs) ok = 1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL cs_fall_timeout got cs=1 exp cs=0");
    end
  endtask

  task automatic test_reset();
    bit ok;
    do_reset();
    @(negedge clk);
    checks++;
    if ({ba.spi_cs, ba.spi_sclk, ba.spi_mosi, ba.ack, ba.busy, ba.slave_select} !== 9'b1_0_0_000_0_00
        || ba.rd_data !== 16'h0) begin
      errors++;
      $display("FAIL reset_state got cs=%b sclk=%b mosi=%b ack=%b busy=%b sel=%0d rd=%h", ba.spi_cs,
               ba.spi_sclk, ba.spi_mosi, ba.ack, ba.busy, ba.slave_select, ba.rd_data);
    end
    // abort mid-shift
    ba.wr_data[0] = 16'($urandom);
    ba.req = 3'b001;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (ba.spi_sclk) ok = 1;
    end
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (!ok || ba.spi_cs !== 1'b1 || ba.spi_sclk !== 1'b0 || ba.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort got shift=%0d cs=%b sclk=%b busy=%b exp 1 1 0 0", ok, ba.spi_cs,
               ba.spi_sclk, ba.busy);
    end
    ba.req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mptr = 0;
    clear_mon();
    repeat (200) @(negedge clk);
    checks++;
    if (aq.size() != 0 || xq_len.size() != 0) begin
      errors++;
      $display("FAIL reset_no_ack got acks=%0d xfers=%0d exp 0 0", aq.size(), xq_len.size());
    end
  endtask

  task automatic test_single();
    logic [2:0] a; bit ok;
    do_reset();
    miso_mode = 0;
    ba.wr_data = {16'($urandom), 16'hA5C3, 16'($urandom)};
    ba.req = 3'b010;
    wait_ack(a, ok);
    ba.req = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (a !== 3'b010 || rq.size() != 1 || rq[0] !== 16'hA5C3) begin
      errors++;
      $display("FAIL single_ack got ack=%b n=%0d rd=%h exp 010 1 a5c3", a, rq.size(),
               (rq.size() > 0) ? rq[0] : 16'hx);
    end
    checks++;
    if (xq_len.size() != 1 || xq_len[0] != (2 * 16 + 2) * 4 || xq_rise[0] != 16 ||
        xq_mosi[0] !== 16'hA5C3 || xq_sel[0] != 1 || xq_selbad[0] != 0) begin
      errors++;
      $display("FAIL single_frame got n=%0d len=%0d rises=%0d mosi=%h sel=%0d exp 1 136 16 a5c3 1",
               xq_len.size(), (xq_len.size() > 0) ? xq_len[0] : -1,
               (xq_rise.size() > 0) ? xq_rise[0] : -1,
               (xq_mosi.size() > 0) ? xq_mosi[0] : 16'hx, (xq_sel.size() > 0) ? xq_sel[0] : -1);
    end
    checks++;
    if (ack_long != 0 || sclk_idle_bad != 0) begin
      errors++;
      $display("FAIL single_pulse got ack_long=%0d sclk_idle=%0d exp 0 0", ack_long, sclk_idle_bad);
    end
  endtask

  task automatic test_random();
    logic [2:0] a; bit ok;
    int r; logic [15:0] w, exp_rd;
    do_reset();
    for (int n = 0; n < 6; n++) begin
      r = $urandom_range(0, 2);
      w = 16'($urandom);
      miso_mode = $urandom_range(0, 1);
      pat = 16'($urandom);
      exp_rd = (miso_mode == 0) ? w : pat;
      ba.wr_data = {16'($urandom), 16'($urandom), 16'($urandom)};
      ba.wr_data[r] = w;
      clear_mon();
      ba.req = 3'(1 << r);
      wait_ack(a, ok);
      ba.req = '0;
      repeat (2) @(negedge clk);
      checks++;
      if (a !== 3'(1 << r) || rq.size() != 1 || rq[0] !== exp_rd || xq_len.size() != 1 ||
          xq_mosi[0] !== w || xq_sel[0] != r || xq_len[0] != 136 || xq_rise[0] != 16) begin
        errors++;
        $display("FAIL random_%0d got ack=%b rd=%h mosi=%h sel=%0d exp ack=%b rd=%h mosi=%h sel=%0d",
                 n, a, (rq.size() > 0) ? rq[0] : 16'hx, (xq_mosi.size() > 0) ? xq_mosi[0] : 16'hx,
                 (xq_sel.size() > 0) ? xq_sel[0] : -1, 3'(1 << r), exp_rd, w, r);
      end
      repeat (6) @(negedge clk);
    end
    miso_mode = 0;
  endtask

  task automatic test_round_robin();
    logic [2:0] a, reqm; bit ok; int g;
    do_reset();
    miso_mode = 0;
    ba.wr_data = {16'($urandom), 16'($urandom), 16'($urandom)};
    ba.req = 3'b111;
    reqm = 3'b111;
    for (int n = 0; n < 3; n++) begin
      g = rr_pick(mptr, reqm);
      reqm[g] = 1'b0;
      mptr = (g + 1) % 3;
      wait_ack(a, ok);
      ba.req = ba.req & ~a;
      checks++;
      if (a !== 3'(1 << g) || ba.rd_data !== ba.wr_data[g]) begin
        errors++;
        $display("FAIL rr_order_%0d got ack=%b rd=%h exp ack=%b rd=%h", n, a, ba.rd_data,
                 3'(1 << g), ba.wr_data[g]);
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (xq_selbad.size() != 3 || xq_selbad.sum() != 0 || gaps.size() != 3 ||
        gaps[1] < 4 || gaps[2] < 4) begin
      errors++;
      $display("FAIL rr_cs_sel got xfers=%0d selbad=%0d gaps=%0d exp 3 0 >=4", xq_selbad.size(),
               xq_selbad.sum(), (gaps.size() > 1) ? gaps[1] : -1);
    end
  endtask

  task automatic test_late_request();
    logic [2:0] a, reqm; bit ok; int g;
    int expg[$];
    do_reset();
    ba.wr_data = {16'($urandom), 16'($urandom), 16'($urandom)};
    // model: req0 alone, then req2 joins, req2 drops after its ack
    reqm = 3'b001;
    g = rr_pick(mptr, reqm); expg.push_back(g); mptr = (g + 1) % 3;
    reqm[2] = 1'b1;
    g = rr_pick(mptr, reqm); expg.push_back(g); mptr = (g + 1) % 3; reqm[g] = 1'b0;
    g = rr_pick(mptr, reqm); expg.push_back(g); mptr = (g + 1) % 3;
    ba.req = 3'b001;
    wait_cs_low_a(ok);
    repeat (20) @(negedge clk);
    ba.req[2] = 1'b1;
    for (int n = 0; n < 3; n++) begin
      wait_ack(a, ok);
      if (a[2]) ba.req[2] = 1'b0;
      checks++;
      if (a !== 3'(1 << expg[n])) begin
        errors++;
        $display("FAIL late_req_%0d got ack=%b exp %b", n, a, 3'(1 << expg[n]));
      end
    end
    ba.req = '0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_req_drop();
    logic [2:0] a; bit ok;
    do_reset();
    ba.wr_data[1] = 16'($urandom);
    ba.req = 3'b010;
    wait_cs_low_a(ok);
    repeat (30) @(negedge clk);
    ba.req = '0;
    wait_ack(a, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (a !== 3'b010 || aq.size() != 1 || ack_long != 0 || rq[0] !== ba.wr_data[1]) begin
      errors++;
      $display("FAIL req_drop got ack=%b n=%0d long=%0d exp 010 1 0", a, aq.size(), ack_long);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (aq.size() != 1 || ba.busy !== 1'b0 || ba.spi_cs !== 1'b1) begin
      errors++;
      $display("FAIL req_drop_idle got acks=%0d busy=%b cs=%b exp 1 0 1", aq.size(), ba.busy,
               ba.spi_cs);
    end
  endtask

  task automatic test_fast_div();
    bit ok; int len, rises, last_rise, per_bad; logic prev;
    do_reset();
    bb.wr_data = {8'($urandom), 8'($urandom), 8'($urandom)};
    bb.req = 3'b001;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (!bb.spi_cs) ok = 1;
    end
    len = 0; rises = 0; last_rise = -1; per_bad = 0; prev = 1'b0;
    while (ok && !bb.spi_cs && len < 1000) begin
      len++;
      if (bb.spi_sclk && !prev) begin
        rises++;
        if (last_rise >= 0 && len - last_rise != 2) per_bad++;
        last_rise = len;
      end
      prev = bb.spi_sclk;
      @(negedge clk);
    end
    checks++;
    if (bb.ack !== 3'b001 || bb.rd_data !== 8'hFF) begin
      errors++;
      $display("FAIL fast_rd got ack=%b rd=%h exp 001 ff", bb.ack, bb.rd_data);
    end
    bb.req = '0;
    checks++;
    if (len != (2 * 8 + 2) * 1 || rises != 8 || per_bad != 0) begin
      errors++;
      $display("FAIL fast_frame got len=%0d rises=%0d per_bad=%0d exp 18 8 0", len, rises, per_bad);
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    ba.req = '0; ba.wr_data = '0;
    bb.req = '0; bb.wr_data = '0;
    test_reset();
    test_single();
    test_random();
    test_round_robin();
    test_late_request();
    test_req_drop();
    test_fast_div();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
